button_press_classifier: RTL
============================

Name: button_press_classifier

Overview:
Consumes the one-cycle debounced edge pulses from the button detector stage and classifies each user gesture as a short press, long press or double press. Emits one single-cycle event pulse per gesture to the road-control FSM and the VGA overlay logic. Time is measured with an internal millisecond tick derived from the system clock.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; TICK_CYC = CLK_HZ/1000 clocks per ms tick
LONG_MS, 1000, hold time in ms that qualifies a long press
DOUBLE_MS, 300, max release-to-second-press gap in ms for a double press

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  reset, synchronous, active-high
rising_edge  in  1  one-cycle press pulse from the button detector
falling_edge  in  1  one-cycle release pulse from the button detector
short_press  out  1  one-cycle pulse: single short click completed
long_press  out  1  one-cycle pulse: hold reached LONG_MS
double_press  out  1  one-cycle pulse: second click released
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, prescaler=0, ms_cnt=0, all outputs 0. Dominates every other input.
- Prescaler counts 0..TICK_CYC-1. tick=1 when prescaler==TICK_CYC-1. Prescaler and ms_cnt clear on every state transition.
- ms_cnt width = clog2(max(LONG_MS,DOUBLE_MS)+1). Increments on tick and saturates, never wraps.
- States and transitions:
  IDLE: rise -> PRESS1.
  PRESS1: fall -> GAP. tick with ms_cnt==LONG_MS-1 -> LONG_HELD and pulse long_press.
  LONG_HELD: fall -> IDLE. Further ticks and repeated rises produce nothing.
  GAP: rise -> PRESS2. tick with ms_cnt==DOUBLE_MS-1 -> IDLE and pulse short_press.
  PRESS2: fall -> IDLE and pulse double_press. tick with ms_cnt==LONG_MS-1 -> LONG_HELD and pulse long_press; the double is discarded.
- Latency: outputs are registered. A pulse is high in the cycle after the deciding clk edge, for exactly one cycle.
- Timeouts: a timeout decided k clocks after an edge is sampled has k = N*TICK_CYC. The pulse is therefore high at edge-sample + N*TICK_CYC + 1.
- Edge and tick in the same cycle: the edge wins and the timeout is not taken.
- rising_edge and falling_edge both high: treated as no event.
- Unexpected edge, e.g. fall in IDLE or rise in PRESS1: ignored, state holds.
- At most one output is high in any cycle. Outputs are never high during or in the cycle after reset.
- busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared package road_ctrl_pkg: press_state_t enum (IDLE, PRESS1, GAP, PRESS2, LONG_HELD) and a TICK_CYC helper constant function.
- One sub-module, ms_tick_gen (prescaler with sync clear, outputs tick). It is reusable by other timed blocks.
- The FSM and ms_cnt stay in the top module.

Test Plan:
All scenarios use CLK_HZ=10_000 (TICK_CYC=10), LONG_MS=20, DOUBLE_MS=5. Cycle numbers are clk edges at which the edge pulse is sampled.
- Short press: rise@0, fall@50 -> short_press high only in cycle 101; no other pulse; busy low from cycle 101.
- Long press: rise@0, fall@400 -> long_press high only in cycle 201; no pulse at the release; busy low after cycle 400.
- Double press: rise@0, fall@30, rise@60, fall@90 -> double_press high only in cycle 91; short_press never asserted.
- Gap just too long: rise@0, fall@30, rise@81 -> short_press high in cycle 81. The rise@81 lands in IDLE, so the bench must then see a fresh PRESS1 (busy stays 1).
- Reset mid-gesture: rise@0, rst=1 in cycles 100-101, no fall -> all outputs 0; busy=0 at cycle 102; no long_press at cycle 201.
- Edge/tick collision: rise@0, fall@200 (coincides with the LONG_MS timeout edge) -> no long_press; FSM enters GAP; short_press high in cycle 251.

Source files
------------

// File: rtl/road_ctrl_pkg.sv
// Shared types and timing helpers for the road-control button path.
package road_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      GAP       = 3'd2,
      PRESS2    = 3'd3,
      LONG_HELD = 3'd4
   } press_state_t;

   // Clock cycles per millisecond tick.
   function automatic int unsigned tick_cyc(input int unsigned clk_hz);
      return clk_hz / 1000;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: free-running 0..TICK_CYC-1 with a synchronous clear.
module ms_tick_gen #(
   parameter int unsigned TICK_CYC = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick_c
);

   localparam int unsigned CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign o_tick_c = (r_cnt == CNT_W'(TICK_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (o_tick_c) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced press/release pulses into short, long and double press events.
module button_press_classifier
   import road_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned LONG_MS   = 1000,
   parameter int unsigned DOUBLE_MS = 300
) (
   input  logic clk,
   input  logic rst,
   input  logic rising_edge,
   input  logic falling_edge,
   output logic short_press,
   output logic long_press,
   output logic double_press,
   output logic busy
);

   localparam int unsigned TICK_CYC = tick_cyc(CLK_HZ);
   localparam int unsigned MS_MAX   = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
   localparam int unsigned MS_W     = $clog2(MS_MAX + 1);

   press_state_t    r_state;
   press_state_t    w_next;
   logic [MS_W-1:0] r_ms_cnt;
   logic            w_tick;
   logic            w_clr;
   logic            w_rise;
   logic            w_fall;
   logic            w_long_to;
   logic            w_double_to;
   logic            w_short;
   logic            w_long;
   logic            w_double;

   // Simultaneous press and release carries no usable information.
   assign w_rise      = rising_edge & ~falling_edge;
   assign w_fall      = falling_edge & ~rising_edge;
   assign w_long_to   = w_tick && (r_ms_cnt == MS_W'(LONG_MS - 1));
   assign w_double_to = w_tick && (r_ms_cnt == MS_W'(DOUBLE_MS - 1));
   assign w_clr       = (w_next != r_state);
   assign busy        = (r_state != IDLE);

   ms_tick_gen #(
      .TICK_CYC (TICK_CYC)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .o_tick_c (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Edges are checked before timeouts so an edge wins a same-cycle tick.
   always_comb begin
      w_next   = r_state;
      w_short  = 1'b0;
      w_long   = 1'b0;
      w_double = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) w_next = PRESS1;
         end
         PRESS1: begin
            if (w_fall) begin
               w_next = GAP;
            end else if (w_long_to) begin
               w_next = LONG_HELD;
               w_long = 1'b1;
            end
         end
         GAP: begin
            if (w_rise) begin
               w_next = PRESS2;
            end else if (w_double_to) begin
               w_next  = IDLE;
               w_short = 1'b1;
            end
         end
         PRESS2: begin
            if (w_fall) begin
               w_next   = IDLE;
               w_double = 1'b1;
            end else if (w_long_to) begin
               w_next = LONG_HELD;
               w_long = 1'b1;
            end
         end
         LONG_HELD: begin
            if (w_fall) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Elapsed milliseconds in the current state, saturating.
   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_ms_cnt <= '0;
      end else if (w_tick && (r_ms_cnt != {MS_W{1'b1}})) begin
         r_ms_cnt <= r_ms_cnt + MS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_press <= 1'b0;
      end else begin
         short_press  <= w_short;
         long_press   <= w_long;
         double_press <= w_double;
      end
   end

endmodule
